shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
- REQ-001 Parameter WIDTH, default 32, meaning datapath width in bits; SHALL be a power of two, minimum 4.
- REQ-002 Parameter SHW, default $clog2(WIDTH) = 5, meaning shift-amount width and iteration count; SHALL be derived from WIDTH and not overridden.
- REQ-003 Port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
- REQ-004 Port rst_n, input, 1, meaning asynchronous active-low reset.
- REQ-005 Port in_valid, input, 1, meaning an operand is presented.
- REQ-006 Port in_ready, output, 1, meaning the unit can accept an operand.
- REQ-007 Port in_data, input, WIDTH, meaning the operand.
- REQ-008 Port in_amt, input, SHW, meaning the shift amount, 0..WIDTH-1.
- REQ-009 Port in_op, input, 2, meaning the operation: 00 SHL, 01 SHR (logical), 10 SAR (arithmetic), 11 ROL.
- REQ-010 Port out_valid, output, 1, meaning a result is held.
- REQ-011 Port out_ready, input, 1, meaning the consumer takes the result.
- REQ-012 Port out_data, output, WIDTH, meaning the result.
- REQ-013 Port out_zero, output, 1, meaning out_data == 0.
- REQ-014 Port busy, output, 1, meaning the state is not IDLE.

Function
- REQ-015 The unit SHALL use FSM states IDLE, RUN and DONE.
- REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
- REQ-017 IDLE -> RUN SHALL occur on an edge with in_valid && in_ready; in_data, in_amt and in_op SHALL be captured and step counter k cleared to 0.
- REQ-018 At each RUN edge, if captured amt bit k = 1, the working register SHALL be shifted by 2^k per the captured op; otherwise it SHALL hold; k SHALL then increment.
- REQ-019 SHL and SHR SHALL fill vacated bits with 0; SAR SHALL fill with the captured bit WIDTH-1; ROL SHALL wrap bits shifted out of the MSB into the LSB.
- REQ-020 RUN -> DONE SHALL occur on the edge that applies step k = SHW-1; latency SHALL be fixed at SHW edges from acceptance to out_valid, for every amount including 0.
- REQ-021 In DONE, out_data and out_zero SHALL be stable until out_valid && out_ready, then the unit SHALL return to IDLE on that edge.
- REQ-022 in_valid and operand inputs SHALL be ignored outside IDLE; there SHALL be no same-cycle accept in DONE, so the minimum issue interval is SHW+2 cycles.
- REQ-023 out_zero SHALL be computed from the final working register and registered with it.
- REQ-024 Changes to in_* after acceptance SHALL NOT affect the in-flight result.

Reset
- REQ-025 While rst_n = 0, state SHALL be IDLE, k = 0, working register = 0, out_data = 0, out_zero = 1, out_valid = 0, busy = 0, and in_ready SHALL be 1 after release.
- REQ-026 Reset asserted in RUN or DONE SHALL abort the operation immediately and discard its result; no out_valid SHALL follow.

Verification (WIDTH = 32)
- REQ-027 SHL 0x00000001, amt 31, out_ready = 1 -> out_data 0x80000000, out_zero 0, out_valid exactly 5 edges after the accept edge.
- REQ-028 SAR 0x80000000, amt 4 -> out_data 0xF8000000; SHR with the same operands -> out_data 0x08000000.
- REQ-029 ROL 0x80000001, amt 1 -> out_data 0x00000003; SHL 0x80000000, amt 1 -> out_data 0x00000000, out_zero 1.
- REQ-030 amt 0, SHL 0x12345678 -> out_data 0x12345678 after 5 edges; hold out_ready = 0 for 3 cycles while driving in_valid with a new operand -> out_data held, in_ready 0, new operand not accepted.
- REQ-031 Pulse rst_n low during RUN at step k = 2 -> all outputs at reset values, no out_valid afterwards; the next operation is correct.

Source files
------------

// File: rtl/shift_unit.sv
// Iterative barrel shifter: one log2 stage per cycle, fixed SHW-cycle latency.
// Valid/ready on both sides; operands are captured at acceptance.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [SHW:0]   WL   = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] KMAX = SHW'(SHW-1);

  state_t           state;
  state_t           state_nx;
  logic [SHW-1:0]   k;
  logic [SHW-1:0]   amt;
  logic [1:0]       op;
  logic             sgn;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step;
  logic             zero;
  logic [SHW:0]     sh;
  logic             take;
  logic             last;

  assign sh   = (SHW+1)'(1) << k;
  assign take = |(amt & (SHW'(1) << k));
  assign last = (k == KMAX);

  // Stage k moves the word by 2^k when amount bit k is set.
  always_comb begin
    step = work;
    if (take) begin
      unique case (op)
        2'b00: step = work << sh;
        2'b01: step = work >> sh;
        2'b10: step = ({WIDTH{sgn}} << (WL - sh)) | (work >> sh);
        2'b11: step = (work << sh) | (work >> (WL - sh));
        default: step = work;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      amt   <= '0;
      op    <= '0;
      sgn   <= 1'b0;
      work  <= '0;
      zero  <= 1'b1;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            amt  <= in_amt;
            op   <= in_op;
            sgn  <= in_data[WIDTH-1];
            k    <= '0;
          end
        end
        RUN: begin
          work <= step;
          k    <= k + SHW'(1);
          if (last) zero <= (step == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;
  assign out_zero  = zero;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit (WIDTH = 32).
// Expected results are queued at acceptance and popped at out_valid.
module tb_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        busy;

  int vectors = 0;
  int errors  = 0;
  logic [32:0] sb[$];

  shift_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_amt(in_amt),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_zero(out_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish, got no summary, required completion");
    $fatal(1);
  end

  function automatic logic [32:0] model(
    input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
    logic [31:0] r;
    case (o)
      2'd0: r = d << a;
      2'd1: r = d >> a;
      2'd2: r = 32'($signed(d) >>> a);
      default: r = (a == 5'd0) ? d :
                   ((d << a) | (d >> (6'd32 - {1'b0, a})));
    endcase
    return {(r == 32'd0), r};
  endfunction

  task automatic drive(
    input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = o;
    in_data  = d;
    in_amt   = a;
    for (int t = 0; t < 40 && !in_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
    in_op    = 2'($urandom);
    sb.push_back(model(o, d, a));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_data !== 32'd0 || out_zero !== 1'b1 ||
        out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h zero=%b valid=%b busy=%b, want 0/1/0/0",
               out_data, out_zero, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_ops;
    logic [1:0]  to[8] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1};
    logic [31:0] td[8] = '{32'h00000001, 32'h80000000, 32'h80000000,
                           32'h80000001, 32'h80000000, 32'hA5A5F00F,
                           32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [4:0]  ta[8] = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd1, 5'd13, 5'd31, 5'd0};
    logic [32:0] exp;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) drive(to[i], td[i], ta[i]);
      else drive(2'($urandom), $urandom, 5'($urandom));
      wait_valid(n);
      exp = (sb.size() > 0) ? sb.pop_front() : 33'h1_0000_0000;
      vectors++;
      if (n !== 5) begin
        errors++;
        $display("FAIL op_latency[%0d]: got %0d edges, want 5", i, n);
      end
      vectors++;
      if (out_data !== exp[31:0] || out_zero !== exp[32]) begin
        errors++;
        $display("FAIL op_result[%0d]: got %h zero=%b, want %h zero=%b",
                 i, out_data, out_zero, exp[31:0], exp[32]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL op_release[%0d]: got valid=%b ready=%b, want 0/1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold;
    logic [32:0] exp;
    int n;
    out_ready = 1'b0;
    drive(2'd0, 32'h12345678, 5'd0);
    wait_valid(n);
    exp = (sb.size() > 0) ? sb.pop_front() : 33'h1_0000_0000;
    vectors++;
    if (n !== 5 || out_data !== exp[31:0] || out_zero !== exp[32]) begin
      errors++;
      $display("FAIL hold_first: got n=%0d data=%h zero=%b, want 5/%h/%b",
               n, out_data, out_zero, exp[31:0], exp[32]);
    end
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_amt   = 5'd3;
    in_op    = 2'd3;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[31:0] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: got valid=%b data=%h ready=%b, want 1/%h/0",
                 c, out_valid, out_data, in_ready, exp[31:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_accept: got busy=%b ready=%b valid=%b, want 0/1/0",
               busy, in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_abort;
    int seen;
    out_ready = 1'b1;
    drive(2'd0, 32'h0000F00F, 5'd7);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (out_data !== 32'd0 || out_zero !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: got data=%h zero=%b valid=%b busy=%b ready=%b, want 0/1/0/0/1",
               out_data, out_zero, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d valid cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp;
    logic [1:0]  o;
    logic [31:0] d;
    logic [4:0]  a;
    int n;
    out_ready = 1'b1;
    @(negedge clk);
    o = 2'd2; d = 32'h80000000; a = 5'd4;
    in_valid = 1'b1; in_op = o; in_data = d; in_amt = a;
    sb.push_back(model(o, d, a));
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_amt   = 5'($urandom);
      in_op    = 2'($urandom);
      wait_valid(n);
      exp = (sb.size() > 0) ? sb.pop_front() : 33'h1_0000_0000;
      vectors++;
      if (n !== 4 + 1 || out_data !== exp[31:0] || out_zero !== exp[32]) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got n=%0d data=%h zero=%b, want 5/%h/%b",
                 i, n, out_data, out_zero, exp[31:0], exp[32]);
      end
      if (i < 11) begin
        o = 2'($urandom); d = $urandom; a = 5'($urandom);
        in_valid = 1'b1; in_op = o; in_data = d; in_amt = a;
        sb.push_back(model(o, d, a));
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap[%0d]: got busy=%b, want 0", i, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_accept[%0d]: got busy=%b, want 1", i, busy);
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
